dm_responder: RTL and testbench

- Multi-cycle data-memory responder. It is the memory-side end of the MEM-stage access interface: the pipeline issues an address, write data and MemRead/MemWrite, and this block answers.
- It serves each access after a programmable latency and holds the pipeline with Stall until the result is ready.
- It replaces the single-cycle data memory so the datapath can be tested against slow memory.
- The array is word-addressed and is cleared on reset.

---
 rtl/dm_responder.sv | 132 +++++++++++++
 tb/tb_dm_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle, word-addressed data memory that answers MEM-stage
// loads and stores after a fixed wait. Stall holds the pipeline while the
// access is pending, and Done marks the single cycle in which the result is
// final.
//
// Handshake: a request (MemRead | MemWrite) is taken only in IDLE, and Stall
// rises in that same cycle. The request is latched at the edge that leaves
// IDLE. Stall then stays high for LATENCY more cycles (BUSY). In the DONE
// cycle Stall is low, Done is high and ReadData is valid. The pipeline
// advances at the edge that closes DONE. Request inputs seen in BUSY or DONE
// are ignored.
module dm_responder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic [15:0] AccessCount
);

  // The wait counter only needs to hold LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   is_write_q, is_write_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [15:0]            access_count_q, access_count_d;
  logic [31:0]            mem_q [DEPTH];
  logic                   mem_we;

  // Next-state, request latching, access execution and output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    is_write_d     = is_write_q;
    read_data_d    = read_data_q;
    access_count_d = access_count_q;
    mem_we         = 1'b0;
    Stall          = 1'b0;
    Done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          // Bits [1:0] and everything above the word index are dropped,
          // so addresses alias modulo DEPTH*4. Read+write counts as a write.
          Stall      = 1'b1;
          idx_d      = Address[ADDR_BITS+1:2];
          wdata_d    = WriteData;
          is_write_d = MemWrite;
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_q == '0) begin
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            read_data_d = mem_q[idx_q];
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        Done           = 1'b1;
        access_count_d = access_count_q + 16'd1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      wdata_q        <= '0;
      is_write_q     <= 1'b0;
      read_data_q    <= '0;
      access_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      wdata_q        <= wdata_d;
      is_write_q     <= is_write_d;
      read_data_q    <= read_data_d;
      access_count_q <= access_count_d;
    end
  end

  // Storage array: cleared by reset, written only on the BUSY-to-DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ReadData    = read_data_q;
  assign AccessCount = access_count_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed plus randomized checks of dm_responder against a
// transaction-level reference that tracks each access by its cycle offset.
module tb_dm_responder;

  localparam int DEPTH     = 256;
  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic [15:0] AccessCount;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  dm_responder #(
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .Done       (Done),
    .AccessCount(AccessCount)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model. m_t is the cycle offset inside an access: -1 means idle;
  // 1..LATENCY are the wait cycles; LATENCY+1 is the completion cycle.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd  = '0;
  logic [15:0] m_cnt = '0;
  int          m_t   = -1;
  int          m_idx = 0;
  logic [31:0] m_wd  = '0;
  bit          m_wr  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_rd  = '0;
      m_cnt = '0;
      m_t   = -1;
    end else if (m_t < 0) begin
      if (MemRead || MemWrite) begin
        m_idx = int'((Address >> 2) % DEPTH);
        m_wd  = WriteData;
        m_wr  = MemWrite;
        m_t   = 1;
      end
    end else if (m_t <= LATENCY) begin
      if (m_t == LATENCY) begin
        if (m_wr) m_mem[m_idx] = m_wd;
        else      m_rd = m_mem[m_idx];
      end
      m_t = m_t + 1;
    end else begin
      m_cnt = m_cnt + 16'd1;
      m_t   = -1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Scoreboard: every out-of-reset cycle, all outputs are compared with the model.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_stall;
      logic exp_done;
      exp_stall = (m_t < 0) ? (MemRead | MemWrite) : (m_t <= LATENCY);
      exp_done  = (m_t == LATENCY + 1);
      check("stall", 32'(Stall), 32'(exp_stall));
      check("done", 32'(Done), 32'(exp_done));
      check("read_data", ReadData, m_rd);
      check("access_count", 32'(AccessCount), 32'(m_cnt));
    end
  end

  // Driver: presents one request, holds it through DONE (optionally scrambling
  // inputs while the access is pending), and reports what was observed.
  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr, input bit scramble,
                        output logic [31:0] rdata, output int stall_n,
                        output int start_c, output int done_c);
    bit got;
    @(posedge clk); #1;
    Address = a; WriteData = d; MemRead = rd; MemWrite = wr;
    start_c = cyc; stall_n = 0; got = 0; rdata = '0; done_c = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (Stall) stall_n++;
      if (Done) begin
        got    = 1;
        rdata  = ReadData;
        done_c = cyc;
      end else if (scramble && k >= 1) begin
        #1;
        Address   = $urandom;
        WriteData = $urandom;
        MemRead   = 1'($urandom_range(0, 1));
        MemWrite  = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL access_timeout cyc=%0d got=no_done exp=done_within_40", cyc);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    Address = $urandom; WriteData = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rdv, a;
    int sn, sc, dc, dc1, kind;
    rst = 1'b1; Address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_read_data", ReadData, 32'h0);
    check("rst_stall", 32'(Stall), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_count", 32'(AccessCount), 32'h0);
    access(32'h10, 32'h0, 1'b1, 1'b0, 1'b0, rdv, sn, sc, dc);
    check("rst_read_0x10", rdv, 32'h0);
    idle();

    // Store then load.
    do_reset();
    access(32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, rdv, sn, sc, dc);
    check("store_stall_cycles", 32'(sn), 32'd4);
    check("store_done_cycle", 32'(dc - sc + 1), 32'd5);
    idle();
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b0, rdv, sn, sc, dc);
    check("load_0x40", rdv, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    check("count_after_two", 32'(AccessCount), 32'd2);

    // Back-to-back writes with the request held through DONE.
    access(32'h0, 32'h11111111, 1'b0, 1'b1, 1'b0, rdv, sn, sc, dc1);
    access(32'h4, 32'h22222222, 1'b0, 1'b1, 1'b0, rdv, sn, sc, dc);
    check("b2b_idle_gap", 32'(sc - dc1), 32'd1);
    check("b2b_done_spacing", 32'(dc - dc1), 32'd5);
    idle();
    @(negedge clk);
    check("b2b_count", 32'(AccessCount), 32'd4);
    access(32'h4, 32'h0, 1'b1, 1'b0, 1'b0, rdv, sn, sc, dc);
    check("b2b_load_0x4", rdv, 32'h22222222);
    idle();

    // Address wrap and alias.
    access(32'h403, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, rdv, sn, sc, dc);
    idle();
    access(32'h000, 32'h0, 1'b1, 1'b0, 1'b0, rdv, sn, sc, dc);
    check("alias_load_0x000", rdv, 32'hCAFEF00D);
    idle();

    // Read and write together behave as a write.
    access(32'h8, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0, rdv, sn, sc, dc);
    check("both_keeps_read_data", rdv, 32'hCAFEF00D);
    idle();
    access(32'h8, 32'h0, 1'b1, 1'b0, 1'b0, rdv, sn, sc, dc);
    check("both_load_0x8", rdv, 32'h5A5A5A5A);
    idle();

    // Reset during the second wait cycle of a write.
    @(posedge clk); #1;
    Address = 32'h20; WriteData = 32'h12345678; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; MemWrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", 32'(Stall), 32'h0);
    check("midrst_count", 32'(AccessCount), 32'h0);
    access(32'h20, 32'h0, 1'b1, 1'b0, 1'b0, rdv, sn, sc, dc);
    check("midrst_load_0x20", rdv, 32'h0);
    idle();

    // Randomized traffic over a few aliased words.
    for (int i = 0; i < 80; i++) begin
      a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) |
          ($urandom & 32'hFFFF_FC00);
      kind = int'($urandom_range(0, 2));
      access(a, $urandom, kind != 1, kind != 0, 1'($urandom_range(0, 1)),
             rdv, sn, sc, dc);
      check("rand_stall_cycles", 32'(sn), 32'(LATENCY + 1));
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
